mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 17 +
 rtl/wait_counter.sv | 28 ++
 rtl/mem_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder.
// Pure declarations, no logic.
package mem_resp_pkg;

    localparam int ADDR_W          = 8;
    localparam int DATA_W          = 8;
    localparam int CNT_W           = 4;
    localparam int DEF_MEM_SIZE    = 128;
    localparam int DEF_WAIT_STATES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter that times the wait phase; zero flags the last wait cycle.
// Load and decrement take effect at the next edge; no backpressure.
module wait_counter
    import mem_resp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding byte memory responder: ready/error pulse WAIT_STATES+2 edges after acceptance.
// New requests are only taken in IDLE; requests arriving while busy are ignored, not queued.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int MEM_SIZE    = DEF_MEM_SIZE,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              wren,
    input  logic              rden,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              error
);

    localparam int               IDX_W       = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_W:0]  MEM_LIMIT   = (ADDR_W + 1)'(MEM_SIZE);
    localparam logic [CNT_W-1:0] LOAD_VAL    = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);
    localparam state_t           ACCEPT_NEXT = (WAIT_STATES == 0) ? RESP : WAIT;

    state_t            state;
    state_t            state_nxt;
    logic              req;
    logic              accept;
    logic              enter_resp;
    logic              cnt_dec;
    logic              cnt_zero;

    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_wren;
    logic              h_rden;

    logic [ADDR_W-1:0] t_addr;
    logic [DATA_W-1:0] t_wdata;
    logic              t_wren;
    logic              t_rden;
    logic              t_bad;
    logic              commit_wr;
    logic              err_q;
    logic [DATA_W-1:0] mem_rd;

    logic [DATA_W-1:0] mem [MEM_SIZE];

    assign req = ce && (wren || rden);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = ACCEPT_NEXT;
            WAIT:    if (cnt_zero) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states RESP is entered at the acceptance edge, so the live inputs are the transaction.
    always_comb begin
        accept     = (state == IDLE) && req;
        enter_resp = (state_nxt == RESP) && (state != RESP);
        cnt_dec    = (state == WAIT);
        if (state == IDLE) begin
            t_addr  = addr;
            t_wdata = wdata;
            t_wren  = wren;
            t_rden  = rden;
        end else begin
            t_addr  = h_addr;
            t_wdata = h_wdata;
            t_wren  = h_wren;
            t_rden  = h_rden;
        end
        t_bad     = ({1'b0, t_addr} >= MEM_LIMIT) || (t_wren && t_rden);
        commit_wr = enter_resp && t_wren && !t_bad && reset;
        mem_rd    = mem[t_addr[IDX_W-1:0]];
    end

    wait_counter u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_addr  <= '0;
            h_wdata <= '0;
            h_wren  <= 1'b0;
            h_rden  <= 1'b0;
        end else if (accept) begin
            h_addr  <= addr;
            h_wdata <= wdata;
            h_wren  <= wren;
            h_rden  <= rden;
        end
    end

    // Status is resolved on entry to RESP but only presented on the edge leaving it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready <= 1'b0;
            error <= 1'b0;
            rdata <= '0;
            err_q <= 1'b0;
        end else begin
            ready <= (state == RESP);
            error <= (state == RESP) && err_q;
            if (enter_resp) begin
                err_q <= t_bad;
                if (t_rden) begin
                    rdata <= t_bad ? '0 : mem_rd;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit_wr) begin
            mem[t_addr[IDX_W-1:0]] <= t_wdata;
        end
    end

endmodule
